// File: rtl/sram_ana_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ana_ctrl
//
// Request-side access controller placed directly upstream of an SRAM macro
// whose pins carry analog-encoded levels. One digital read or write request
// is accepted at a time over a valid/ready handshake. The controller drives
// the macro's encoded bus with a setup / strobe / capture sequence, then
// thresholds the returned levels into digital read data. That data is
// returned over a valid/ready response port.
//
// Every logic bit on the analog side is an ANA_WIDTH-bit level. A logic 1
// is FULL_SCALE and a logic 0 is zero; no other level is ever driven.
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   req_valid     in   request present
//   req_ready     out  controller can accept a request (only in IDLE)
//   req_we        in   1 = write, 0 = read
//   req_addr      in   word address
//   req_wdata     in   write data
//   rsp_valid     out  response available
//   rsp_ready     in   consumer accepts the response
//   rsp_rdata     out  decoded read data (old contents for a write)
//   rsp_marginal  out  some dout_a level fell in [THRESH_LO, THRESH_HI)
//   clk_a         out  encoded SRAM clock
//   we_a          out  encoded write enable
//   addr_a[]      out  encoded address bits, one level per bit
//   din_a[]       out  encoded write data bits, one level per bit
//   dout_a[]      in   encoded read data bits from the SRAM
// -----------------------------------------------------------------------------
module sram_ana_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int ANA_WIDTH    = 8,
    parameter int FULL_SCALE   = 255,
    parameter int THRESH_HI    = 160,
    parameter int THRESH_LO    = 96,
    parameter int SETUP_CYCLES = 1,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_marginal,

    output logic [ANA_WIDTH-1:0]  clk_a,
    output logic [ANA_WIDTH-1:0]  we_a,
    output logic [ANA_WIDTH-1:0]  addr_a [ADDR_WIDTH],
    output logic [ANA_WIDTH-1:0]  din_a  [DATA_WIDTH],
    input  logic [ANA_WIDTH-1:0]  dout_a [DATA_WIDTH]
);

    // -------------------------------------------------------------------------
    // Level constants and the phase counter.
    // -------------------------------------------------------------------------
    localparam logic [ANA_WIDTH-1:0] LVL_ONE  = ANA_WIDTH'(FULL_SCALE);
    localparam logic [ANA_WIDTH-1:0] LVL_ZERO = '0;
    localparam logic [ANA_WIDTH-1:0] LVL_HI   = ANA_WIDTH'(THRESH_HI);
    localparam logic [ANA_WIDTH-1:0] LVL_LO   = ANA_WIDTH'(THRESH_LO);

    // One counter serves both SETUP and STROBE. It is sized for the longer
    // of the two phases.
    localparam int CNT_MAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        CAPTURE,
        RESP
    } state_e;

    // Digital bit -> analog level.
    function automatic logic [ANA_WIDTH-1:0] enc(input logic b);
        return b ? LVL_ONE : LVL_ZERO;
    endfunction

    // -------------------------------------------------------------------------
    // State and registered outputs.
    // -------------------------------------------------------------------------
    state_e                 state_q,        state_d;
    logic [CNT_W-1:0]       cnt_q,          cnt_d;
    logic                   req_ready_q,    req_ready_d;
    logic                   rsp_valid_q,    rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q,    rsp_rdata_d;
    logic                   rsp_marginal_q, rsp_marginal_d;
    logic [ANA_WIDTH-1:0]   clk_a_q,        clk_a_d;
    logic [ANA_WIDTH-1:0]   we_a_q,         we_a_d;
    logic [ANA_WIDTH-1:0]   addr_a_q [ADDR_WIDTH];
    logic [ANA_WIDTH-1:0]   addr_a_d [ADDR_WIDTH];
    logic [ANA_WIDTH-1:0]   din_a_q  [DATA_WIDTH];
    logic [ANA_WIDTH-1:0]   din_a_d  [DATA_WIDTH];

    // -------------------------------------------------------------------------
    // Read-data thresholding.
    // A level below THRESH_LO decodes to 0. A level at or above THRESH_HI
    // decodes to 1. Anything in between also decodes to 0, but it raises
    // the marginal flag so that the consumer can tell a weak 1 from a clean 0.
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rd_bits;
    logic                  rd_marginal;

    always_comb begin
        rd_bits     = '0;
        rd_marginal = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            rd_bits[i]  = (dout_a[i] >= LVL_HI);
            rd_marginal = rd_marginal | ((dout_a[i] >= LVL_LO) && (dout_a[i] < LVL_HI));
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d starts as its _q. A path that forgets to assign a
        // signal then simply holds state, and no latch can be inferred.
        state_d        = state_q;
        cnt_d          = cnt_q;
        req_ready_d    = req_ready_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_marginal_d = rsp_marginal_q;
        clk_a_d        = clk_a_q;
        we_a_d         = we_a_q;
        addr_a_d       = addr_a_q;
        din_a_d        = din_a_q;

        unique case (state_q)
            IDLE: begin
                // After reset, req_ready_q is 0. It rises on the first edge
                // spent in IDLE, so the first request is taken one edge later.
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    for (int i = 0; i < ADDR_WIDTH; i++) begin
                        addr_a_d[i] = enc(req_addr[i]);
                    end
                    for (int i = 0; i < DATA_WIDTH; i++) begin
                        din_a_d[i] = enc(req_wdata[i]);
                    end
                    we_a_d  = enc(req_we);
                    clk_a_d = LVL_ZERO;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                // The bus has been stable since the accept edge. clk_a rises
                // exactly SETUP_CYCLES edges after acceptance.
                if (cnt_q == SETUP_LAST) begin
                    clk_a_d = LVL_ONE;
                    cnt_d   = '0;
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STROBE: begin
                // addr_a and din_a are not touched here, so they stay stable
                // for the whole high phase of clk_a.
                if (cnt_q == HOLD_LAST) begin
                    clk_a_d = LVL_ZERO;
                    we_a_d  = LVL_ZERO;
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            CAPTURE: begin
                rsp_rdata_d    = rd_bits;
                rsp_marginal_d = rd_marginal;
                rsp_valid_d    = 1'b1;
                state_d        = RESP;
            end

            RESP: begin
                // A request arriving in the same cycle as the response
                // handshake is not taken here. req_ready only rises on this
                // edge, so that request is accepted on the next edge.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples its pre-edge inputs, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            req_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_marginal_q <= 1'b0;
            clk_a_q        <= LVL_ZERO;
            we_a_q         <= LVL_ZERO;
            // NOTE: these per-bit arrays are bus pins, not storage. They must
            // return to zero the instant reset asserts, so each element gets
            // an asynchronous reset (a RAM-style array would be left unreset).
            for (int i = 0; i < ADDR_WIDTH; i++) begin
                addr_a_q[i] <= LVL_ZERO;
            end
            for (int i = 0; i < DATA_WIDTH; i++) begin
                din_a_q[i] <= LVL_ZERO;
            end
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_marginal_q <= rsp_marginal_d;
            clk_a_q        <= clk_a_d;
            we_a_q         <= we_a_d;
            for (int i = 0; i < ADDR_WIDTH; i++) begin
                addr_a_q[i] <= addr_a_d[i];
            end
            for (int i = 0; i < DATA_WIDTH; i++) begin
                din_a_q[i] <= din_a_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs come straight from registers.
    // -------------------------------------------------------------------------
    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_marginal = rsp_marginal_q;
    assign clk_a        = clk_a_q;
    assign we_a         = we_a_q;
    assign addr_a       = addr_a_q;
    assign din_a        = din_a_q;

endmodule

// File: tb/tb_sram_ana_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_ana_ctrl
//
// Self-checking bench for sram_ana_ctrl.
//
// A behavioural read-first SRAM reacts to the encoded bus. It can be bypassed
// by a level override on dout_a. Expected responses come from a word-array
// model of memory contents and from the thresholding rule, applied to the
// override levels with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_sram_ana_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int NW    = 1 << AW;
    localparam int SETUP = 1;
    localparam int HOLD  = 1;
    localparam int TH_HI = 160;
    localparam int TH_LO = 96;
    localparam int LAT   = SETUP + HOLD + 1;
    localparam logic [7:0] FS = 8'd255;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we    = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_ready = 1'b0;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_marginal;
    logic [7:0]    clk_a;
    logic [7:0]    we_a;
    logic [7:0]    addr_a [AW];
    logic [7:0]    din_a  [DW];
    logic [7:0]    dout_a [DW];

    int checks    = 0;
    int errors    = 0;
    int acc_count = 0;
    int exp_acc   = 0;

    always #5 clk = ~clk;

    sram_ana_ctrl #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .ANA_WIDTH   (8),
        .FULL_SCALE  (255),
        .THRESH_HI   (TH_HI),
        .THRESH_LO   (TH_LO),
        .SETUP_CYCLES(SETUP),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_marginal(rsp_marginal),
        .clk_a       (clk_a),
        .we_a        (we_a),
        .addr_a      (addr_a),
        .din_a       (din_a),
        .dout_a      (dout_a)
    );

    // ---------------- Behavioural read-first SRAM ----------------
    logic [DW-1:0] mem [NW] = '{default: '0};
    logic [DW-1:0] sram_dout = '0;
    logic          sram_clk;

    function automatic logic [AW-1:0] addr_bits();
        logic [AW-1:0] v = '0;
        for (int i = 0; i < AW; i++) v[i] = (addr_a[i] == FS);
        return v;
    endfunction

    function automatic logic [DW-1:0] din_bits();
        logic [DW-1:0] v = '0;
        for (int i = 0; i < DW; i++) v[i] = (din_a[i] == FS);
        return v;
    endfunction

    assign sram_clk = (clk_a == FS);

    always @(posedge sram_clk) begin
        sram_dout <= mem[addr_bits()];
        if (we_a == FS) mem[addr_bits()] <= din_bits();
    end

    logic       ovr_en = 1'b0;
    logic [7:0] ovr [DW] = '{default: 8'd255};

    always_comb begin
        for (int i = 0; i < DW; i++) begin
            dout_a[i] = ovr_en ? ovr[i] : (sram_dout[i] ? FS : 8'd0);
        end
    end

    // Count every request handshake seen on the port.
    always @(posedge clk) begin
        if (rst_n && req_valid && req_ready) acc_count++;
    end

    // ---------------- Reference model ----------------
    logic [DW-1:0] exp_mem [NW] = '{default: '0};
    logic          nxt_we   = 1'b0;
    logic [AW-1:0] nxt_addr = '0;
    logic [DW-1:0] nxt_wdata = '0;

    // Thresholding rule applied to the override levels.
    task automatic model_ovr(output logic [DW-1:0] d, output logic m);
        d = '0;
        m = 1'b0;
        for (int i = 0; i < DW; i++) begin
            d[i] = (int'(ovr[i]) >= TH_HI);
            if (int'(ovr[i]) >= TH_LO && int'(ovr[i]) < TH_HI) m = 1'b1;
        end
    endtask

    // Strict decode: returns -1 if any level is neither 0 nor FULL_SCALE.
    function automatic int dec_addr();
        int v = 0;
        for (int i = 0; i < AW; i++) begin
            if (addr_a[i] == FS) v = v | (1 << i);
            else if (addr_a[i] != 8'd0) return -1;
        end
        return v;
    endfunction

    function automatic int dec_din();
        int v = 0;
        for (int i = 0; i < DW; i++) begin
            if (din_a[i] == FS) v = v | (1 << i);
            else if (din_a[i] != 8'd0) return -1;
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_clk_a"},     32'(clk_a), 32'd0);
        check({tag, "_we_a"},      32'(we_a), 32'd0);
        check({tag, "_addr_a"},    32'(dec_addr()), 32'd0);
        check({tag, "_din_a"},     32'(dec_din()), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
        check({tag, "_rsp_marg"},  32'(rsp_marginal), 32'd0);
    endtask

    // Present one request from a negedge and follow it to its response.
    // keep = leave req_valid high with nxt_* fields after the accept.
    task automatic run_txn(input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int bp,
                           input logic keep, output int waited);
        logic [DW-1:0] exp_rd;
        logic          exp_m;
        int            rise_n;
        int            rsp_n;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        waited    = 0;
        while (req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("accept_in_bound", 32'(waited < 20), 32'd1);
        if (ovr_en) model_ovr(exp_rd, exp_m);
        else begin
            exp_rd = exp_mem[addr];
            exp_m  = 1'b0;
        end
        if (we) exp_mem[addr] = wdata;
        exp_acc++;
        @(posedge clk);             // accept edge
        @(negedge clk);
        if (keep) begin
            req_we    = nxt_we;
            req_addr  = nxt_addr;
            req_wdata = nxt_wdata;
        end else begin
            req_valid = 1'b0;
        end
        rise_n = -1;
        rsp_n  = -1;
        for (int n = 0; n < 30 && rsp_n < 0; n++) begin
            if (n > 0) @(negedge clk);
            if (clk_a === FS && rise_n < 0) begin
                rise_n = n;
                check("strobe_addr_a", 32'(dec_addr()), 32'(addr));
                check("strobe_din_a",  32'(dec_din()),  32'(wdata));
                check("strobe_we_a",   32'(we_a), we ? 32'd255 : 32'd0);
            end
            if (rsp_valid === 1'b1) rsp_n = n;
        end
        check("clk_a_rise_cycle", 32'(rise_n), 32'(SETUP));
        check("rsp_latency",      32'(rsp_n),  32'(LAT));
        check("rsp_rdata",        32'(rsp_rdata), 32'(exp_rd));
        check("rsp_marginal",     32'(rsp_marginal), 32'(exp_m));
        check("resp_clk_we_low",  32'({clk_a, we_a}), 32'd0);
        for (int b = 0; b < bp; b++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata_hold", 32'(rsp_rdata), 32'(exp_rd));
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_req_ready", 32'(req_ready), 32'd1);
    endtask

    // Accept a request, then pulse reset at negedge at_n after acceptance.
    task automatic abort_txn(input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input int at_n);
        int waited = 0;
        logic saw_rsp = 1'b0;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("abort_accept_in_bound", 32'(waited < 20), 32'd1);
        exp_acc++;
        // The write reaches the SRAM only if clk_a has already risen.
        if (we && at_n >= SETUP) exp_mem[addr] = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (at_n) @(negedge clk);
        check("abort_clk_a_state", 32'(clk_a), (at_n >= SETUP && at_n < SETUP + HOLD) ? 32'd255 : 32'd0);
        #2 rst_n = 1'b0;
        #1 check_reset_state("abort");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("abort_req_ready_pre_edge", 32'(req_ready), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
        end
        check("abort_no_rsp", 32'(saw_rsp), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w;
        int acc_before;

        // Reset and release.
        #2 rst_n = 1'b0;
        #1 check_reset_state("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check("req_ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("req_ready_after_edge", 32'(req_ready), 32'd1);

        // Directed writes/reads, read-first behaviour, address wrap ends.
        run_txn(1'b1, 4'd2,  8'hA5, 0, 1'b0, w);
        run_txn(1'b0, 4'd2,  8'h00, 0, 1'b0, w);
        run_txn(1'b1, 4'd2,  8'h3C, 0, 1'b0, w);
        run_txn(1'b0, 4'd2,  8'h00, 0, 1'b0, w);
        run_txn(1'b1, 4'd15, 8'h5A, 0, 1'b0, w);
        run_txn(1'b1, 4'd0,  8'hC3, 0, 1'b0, w);
        run_txn(1'b0, 4'd15, 8'hFF, 0, 1'b0, w);
        run_txn(1'b0, 4'd0,  8'h00, 0, 1'b0, w);

        // Threshold boundaries on one bit, others at full scale.
        ovr_en = 1'b1;
        ovr[3] = 8'd128; run_txn(1'b0, 4'd1, 8'h00, 0, 1'b0, w);
        ovr[3] = 8'd160; run_txn(1'b0, 4'd1, 8'h00, 0, 1'b0, w);
        ovr[3] = 8'd159; run_txn(1'b0, 4'd1, 8'h00, 0, 1'b0, w);
        ovr[3] = 8'd96;  run_txn(1'b0, 4'd1, 8'h00, 0, 1'b0, w);
        ovr[3] = 8'd95;  run_txn(1'b0, 4'd1, 8'h00, 0, 1'b0, w);
        ovr[3] = 8'd255;
        ovr[6] = 8'd0;   run_txn(1'b0, 4'd1, 8'h00, 0, 1'b0, w);
        ovr[6] = 8'd255;
        ovr_en = 1'b0;

        // Backpressure with a second request held pending throughout.
        acc_before = acc_count;
        nxt_we    = 1'b0;
        nxt_addr  = 4'd2;
        nxt_wdata = 8'h00;
        run_txn(1'b1, 4'd4, 8'h66, 5, 1'b1, w);
        run_txn(1'b0, 4'd2, 8'h00, 0, 1'b0, w);
        check("second_req_next_edge", 32'(w), 32'd0);
        repeat (4) @(negedge clk);
        check("accepted_exactly_twice", 32'(acc_count - acc_before), 32'd2);
        run_txn(1'b0, 4'd4, 8'h00, 0, 1'b0, w);

        // Reset during SETUP (write never reaches SRAM), then during STROBE.
        run_txn(1'b1, 4'd7, 8'h11, 0, 1'b0, w);
        abort_txn(1'b1, 4'd7, 8'h99, 0);
        run_txn(1'b0, 4'd7, 8'h00, 0, 1'b0, w);
        abort_txn(1'b0, 4'd2, 8'h00, SETUP);
        run_txn(1'b0, 4'd2, 8'h00, 0, 1'b0, w);

        // Randomized traffic against the word model.
        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                    int'($urandom_range(0, 2)), 1'b0, w);
        end

        repeat (3) @(negedge clk);
        check("total_accepts", 32'(acc_count), 32'(exp_acc));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
